// File: rtl/ldm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ldm_ctrl_pkg
// Shared definitions for the LDM/STM block-transfer sequencer:
//   - sequencer state encodings (IDLE / XFER / WB)
//   - register-list width, counter width and default word stride
//   - popcount helper used to size the transfer at issue
// ----------------------------------------------------------------------------
package ldm_ctrl_pkg;

    localparam int unsigned REG_LIST_W     = 16;
    // Wide enough to hold a count of 16 registers
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned LDM_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        LDM_IDLE = 2'd0,
        LDM_XFER = 2'd1,
        LDM_WB   = 2'd2
    } ldm_state_e;

    // Number of registers named in a 16-bit register list
    function automatic logic [CNT_W-1:0] popcount16(input logic [REG_LIST_W-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = 5'd0;
        for (int k = 0; k < REG_LIST_W; k++) begin
            cnt = cnt + CNT_W'(vec[k]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldm_ctrl_prio_enc16.sv
// ----------------------------------------------------------------------------
// ldm_ctrl_prio_enc16
// Lowest-set-bit priority encoder for a 16-bit register list.
//   vec : input list
//   idx : index of the lowest set bit (0 when vec is empty)
//   vld : 1 when any bit of vec is set
// ----------------------------------------------------------------------------
module ldm_ctrl_prio_enc16
    import ldm_ctrl_pkg::*;
(
    input  logic [REG_LIST_W-1:0] vec,
    output logic [3:0]            idx,
    output logic                  vld
);

    logic [3:0] idx_s;
    logic       vld_s;

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx_s = 4'd0;
        vld_s = 1'b0;
        for (int k = REG_LIST_W - 1; k >= 0; k--) begin
            if (vec[k]) begin
                idx_s = 4'(k);
                vld_s = 1'b1;
            end else begin
                vld_s = vld_s;
            end
        end
    end

    assign idx = idx_s;
    assign vld = vld_s;

endmodule

// File: rtl/ldm_ctrl.sv
// ----------------------------------------------------------------------------
// ldm_ctrl
// ARMv4 LDM/STM sequencer. Walks the latched register list lowest-first,
// driving the EX-stage override (offset, register code, store data, memory
// strobe), then an optional base-writeback cycle, holding fetch/decode until
// the final cycle of the sequence.
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start, i_reg_list    block-transfer issue and register list
//   i_load/i_up/i_pre/i_wb L, U, P, W bits of the instruction
//   i_stall                freezes the sequencer and its outputs
//   o_ldm_vld              EX override select
//   o_ldm_offset           unsigned byte offset from the base
//   o_ldm_mem_vld          memory access this cycle
//   o_ldm_reg_code         register being transferred
//   o_reg_rd_code          register-file read address for store data
//   i_reg_rd_data          register-file read data
//   o_ldm_reg              store data (STM transfers only)
//   o_ldm_wb_base          base-writeback cycle
//   o_hold                 hold fetch/decode, keep instruction in EX
//   o_busy                 sequencer not idle
// ----------------------------------------------------------------------------
module ldm_ctrl
    import ldm_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WORD_BYTES = LDM_WORD_BYTES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [REG_LIST_W-1:0] i_reg_list,
    input  logic                  i_load,
    input  logic                  i_up,
    input  logic                  i_pre,
    input  logic                  i_wb,
    input  logic                  i_stall,
    output logic                  o_ldm_vld,
    output logic [DATA_W-1:0]     o_ldm_offset,
    output logic                  o_ldm_mem_vld,
    output logic [3:0]            o_ldm_reg_code,
    output logic [3:0]            o_reg_rd_code,
    input  logic [DATA_W-1:0]     i_reg_rd_data,
    output logic [DATA_W-1:0]     o_ldm_reg,
    output logic                  o_ldm_wb_base,
    output logic                  o_hold,
    output logic                  o_busy
);

    ldm_state_e            state_r, state_s;
    logic [REG_LIST_W-1:0] list_r, list_s;
    logic [CNT_W-1:0]      idx_r, idx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  load_r, load_s;
    logic                  up_r, up_s;
    logic                  pre_r, pre_s;
    logic                  wb_r, wb_s;

    logic [3:0]            cur_code_s;
    logic                  cur_vld_s;
    logic [REG_LIST_W-1:0] rest_list_s;
    logic [3:0]            rest_idx_unused_s;
    logic                  rest_vld_s;
    logic                  last_s;
    logic [CNT_W-1:0]      issue_cnt_s;
    logic [CNT_W-1:0]      word_s;
    logic [DATA_W-1:0]     xfer_offset_s;
    logic [DATA_W-1:0]     wb_offset_s;

    logic                  vld_s, mem_vld_s, wb_base_s, hold_s;
    logic [3:0]            code_s;
    logic [DATA_W-1:0]     offset_s, reg_data_s;

    ldm_ctrl_prio_enc16 u_cur_enc (
        .vec (list_r),
        .idx (cur_code_s),
        .vld (cur_vld_s)
    );

    // Remaining list with the current register removed; empty means last one
    assign rest_list_s = list_r & (list_r - 16'd1);

    ldm_ctrl_prio_enc16 u_rest_enc (
        .vec (rest_list_s),
        .idx (rest_idx_unused_s),
        .vld (rest_vld_s)
    );

    assign last_s      = cur_vld_s & ~rest_vld_s;
    assign issue_cnt_s = popcount16(i_reg_list);

    // Word index from the base for the current transfer, by addressing mode
    always_comb begin
        case ({up_r, pre_r})
            2'b10:   word_s = idx_r;                  // IA
            2'b11:   word_s = idx_r + 5'd1;           // IB
            2'b00:   word_s = cnt_r - idx_r - 5'd1;   // DA
            2'b01:   word_s = cnt_r - idx_r;          // DB
            default: word_s = 5'd0;
        endcase
    end

    assign xfer_offset_s = DATA_W'(word_s) * DATA_W'(WORD_BYTES);
    assign wb_offset_s   = DATA_W'(cnt_r) * DATA_W'(WORD_BYTES);

    // Next-state and EX override decode; stall keeps everything in place
    always_comb begin
        state_s    = state_r;
        list_s     = list_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        load_s     = load_r;
        up_s       = up_r;
        pre_s      = pre_r;
        wb_s       = wb_r;
        vld_s      = 1'b0;
        mem_vld_s  = 1'b0;
        wb_base_s  = 1'b0;
        hold_s     = 1'b0;
        code_s     = 4'd0;
        offset_s   = '0;
        reg_data_s = '0;
        case (state_r)
            LDM_IDLE: begin
                if (i_start && !i_stall) begin
                    list_s = i_reg_list;
                    cnt_s  = issue_cnt_s;
                    idx_s  = 5'd0;
                    load_s = i_load;
                    up_s   = i_up;
                    pre_s  = i_pre;
                    wb_s   = i_wb;
                    if (issue_cnt_s != 5'd0) begin
                        state_s = LDM_XFER;
                    end else if (i_wb) begin
                        state_s = LDM_WB;
                    end else begin
                        state_s = LDM_IDLE;
                    end
                    hold_s = (state_s != LDM_IDLE);
                end else begin
                    hold_s = 1'b0;
                end
            end
            LDM_XFER: begin
                vld_s      = 1'b1;
                mem_vld_s  = 1'b1;
                code_s     = cur_code_s;
                offset_s   = xfer_offset_s;
                reg_data_s = load_r ? '0 : i_reg_rd_data;
                // Released only on the cycle that actually completes the sequence
                hold_s     = !(last_s && !wb_r && !i_stall);
                if (!i_stall) begin
                    list_s = rest_list_s;
                    idx_s  = idx_r + 5'd1;
                    if (last_s) begin
                        state_s = wb_r ? LDM_WB : LDM_IDLE;
                    end else begin
                        state_s = LDM_XFER;
                    end
                end else begin
                    state_s = LDM_XFER;
                end
            end
            LDM_WB: begin
                vld_s     = 1'b1;
                wb_base_s = 1'b1;
                offset_s  = wb_offset_s;
                hold_s    = i_stall;
                if (!i_stall) begin
                    state_s = LDM_IDLE;
                end else begin
                    state_s = LDM_WB;
                end
            end
            default: begin
                state_s = LDM_IDLE;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= LDM_IDLE;
            list_r  <= 16'd0;
            idx_r   <= 5'd0;
            cnt_r   <= 5'd0;
            load_r  <= 1'b0;
            up_r    <= 1'b0;
            pre_r   <= 1'b0;
            wb_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            list_r  <= list_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            load_r  <= load_s;
            up_r    <= up_s;
            pre_r   <= pre_s;
            wb_r    <= wb_s;
        end
    end

    assign o_ldm_vld      = vld_s;
    assign o_ldm_mem_vld  = mem_vld_s;
    assign o_ldm_wb_base  = wb_base_s;
    assign o_ldm_reg_code = code_s;
    assign o_reg_rd_code  = code_s;
    assign o_ldm_offset   = offset_s;
    assign o_ldm_reg      = reg_data_s;
    assign o_hold         = hold_s;
    assign o_busy         = (state_r != LDM_IDLE);

endmodule

// File: tb/tb_ldm_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ldm_ctrl
// Scoreboard bench for ldm_ctrl: stimulus pushes hand-computed expected
// override cycles; a negedge monitor compares every o_ldm_vld cycle against
// the queue head (popping only on non-stalled cycles) and checks that all
// outputs are quiet otherwise.
// ----------------------------------------------------------------------------
module tb_ldm_ctrl;

    typedef struct {
        logic        mem;
        logic        wb;
        logic [3:0]  code;
        logic [31:0] off;
        logic        hold;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_reg_list;
    logic        i_load, i_up, i_pre, i_wb, i_stall;
    logic        o_ldm_vld, o_ldm_mem_vld, o_ldm_wb_base, o_hold, o_busy;
    logic [31:0] o_ldm_offset, i_reg_rd_data, o_ldm_reg;
    logic [3:0]  o_ldm_reg_code, o_reg_rd_code;

    exp_t sb[$];
    exp_t e;
    int   compared   = 0;
    int   mismatched = 0;
    int   timeout_cnt  = 0;
    int   timeout_seen = 0;
    logic exp_hold_idle = 1'b0;
    logic exp_h;

    ldm_ctrl #(.DATA_W(32), .WORD_BYTES(4)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_reg_list     (i_reg_list),
        .i_load         (i_load),
        .i_up           (i_up),
        .i_pre          (i_pre),
        .i_wb           (i_wb),
        .i_stall        (i_stall),
        .o_ldm_vld      (o_ldm_vld),
        .o_ldm_offset   (o_ldm_offset),
        .o_ldm_mem_vld  (o_ldm_mem_vld),
        .o_ldm_reg_code (o_ldm_reg_code),
        .o_reg_rd_code  (o_reg_rd_code),
        .i_reg_rd_data  (i_reg_rd_data),
        .o_ldm_reg      (o_ldm_reg),
        .o_ldm_wb_base  (o_ldm_wb_base),
        .o_hold         (o_hold),
        .o_busy         (o_busy)
    );

    // Register-file model: Rk reads as 0x1000_000k
    assign i_reg_rd_data = 32'h1000_0000 | {28'd0, o_reg_rd_code};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: scoreboard compare on override cycles, quiet check otherwise
    always @(negedge clk) begin
        if (timeout_cnt != timeout_seen) begin
            timeout_seen = timeout_cnt;
            compared++;
            mismatched++;
            $display("FAIL timeout: sequence did not complete, queue=%0d busy=%0b (required queue=0 busy=0)",
                     sb.size(), o_busy);
        end
        if (o_ldm_vld) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_cycle: got code=%0d off=%0d mem=%0b wb=%0b, required no override cycle",
                         o_ldm_reg_code, o_ldm_offset, o_ldm_mem_vld, o_ldm_wb_base);
            end else begin
                e = sb[0];
                exp_h = i_stall ? 1'b1 : e.hold;
                if (o_ldm_mem_vld !== e.mem || o_ldm_wb_base !== e.wb ||
                    o_ldm_reg_code !== e.code || o_reg_rd_code !== e.code ||
                    o_ldm_offset !== e.off || o_hold !== exp_h ||
                    o_ldm_reg !== e.data || o_busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL xfer_cycle: got mem=%0b wb=%0b code=%0d rd=%0d off=%0d hold=%0b data=%h busy=%0b; required mem=%0b wb=%0b code=%0d off=%0d hold=%0b data=%h busy=1",
                             o_ldm_mem_vld, o_ldm_wb_base, o_ldm_reg_code, o_reg_rd_code,
                             o_ldm_offset, o_hold, o_ldm_reg, o_busy,
                             e.mem, e.wb, e.code, e.off, exp_h, e.data);
                end
                if (!i_stall) begin
                    void'(sb.pop_front());
                end
            end
        end else begin
            compared++;
            if (o_ldm_mem_vld !== 1'b0 || o_ldm_wb_base !== 1'b0 || o_ldm_reg_code !== 4'd0 ||
                o_reg_rd_code !== 4'd0 || o_ldm_offset !== 32'd0 || o_ldm_reg !== 32'd0 ||
                o_busy !== 1'b0 || o_hold !== exp_hold_idle) begin
                mismatched++;
                $display("FAIL idle_outputs: got mem=%0b wb=%0b code=%0d rd=%0d off=%0d data=%h busy=%0b hold=%0b; required all 0, hold=%0b",
                         o_ldm_mem_vld, o_ldm_wb_base, o_ldm_reg_code, o_reg_rd_code,
                         o_ldm_offset, o_ldm_reg, o_busy, o_hold, exp_hold_idle);
            end
        end
    end

    task automatic push(input logic mem, input logic wb, input logic [3:0] code,
                        input logic [31:0] off, input logic hold, input logic [31:0] data);
        exp_t x;
        x.mem = mem; x.wb = wb; x.code = code; x.off = off; x.hold = hold; x.data = data;
        sb.push_back(x);
    endtask

    // Issue one instruction; optional stall cycles or a busy-time start pulse
    task automatic start_seq(input logic [15:0] list, input logic ld, input logic up,
                             input logic pre, input logic wb, input int stall_n,
                             input logic pulse);
        @(posedge clk); #1;
        i_start = 1'b1; i_reg_list = list; i_load = ld; i_up = up; i_pre = pre; i_wb = wb;
        exp_hold_idle = (list != 16'd0) || wb;
        @(posedge clk); #1;
        exp_hold_idle = 1'b0;
        i_start = pulse;
        if (pulse) begin
            i_reg_list = 16'hFFFF; i_load = ~ld; i_up = ~up; i_pre = ~pre; i_wb = ~wb;
            @(posedge clk); #1;
        end
        if (stall_n > 0) begin
            i_stall = 1'b1;
            for (int k = 0; k < stall_n; k++) begin
                @(posedge clk); #1;
            end
        end
        i_start = 1'b0;
        i_stall = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_busy) done = 1'b1;
        end
        if (!done) begin
            timeout_cnt++;
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_reg_list = 16'd0;
        i_load = 1'b0; i_up = 1'b0; i_pre = 1'b0; i_wb = 1'b0; i_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;

        // LDMIA {r0-r3}!: offsets 0,4,8,12 then writeback 16
        push(1'b1, 1'b0, 4'd0, 32'd0,  1'b1, 32'd0);
        push(1'b1, 1'b0, 4'd1, 32'd4,  1'b1, 32'd0);
        push(1'b1, 1'b0, 4'd2, 32'd8,  1'b1, 32'd0);
        push(1'b1, 1'b0, 4'd3, 32'd12, 1'b1, 32'd0);
        push(1'b0, 1'b1, 4'd0, 32'd16, 1'b0, 32'd0);
        start_seq(16'h000F, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        wait_done();

        // STMDB {r4,r14}: offsets 8,4, store data from the register file
        push(1'b1, 1'b0, 4'd4,  32'd8, 1'b1, 32'h1000_0004);
        push(1'b1, 1'b0, 4'd14, 32'd4, 1'b0, 32'h1000_000E);
        start_seq(16'h4010, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        wait_done();

        // LDMIB {r0,r15} with a 3-cycle stall on r0
        push(1'b1, 1'b0, 4'd0,  32'd4, 1'b1, 32'd0);
        push(1'b1, 1'b0, 4'd15, 32'd8, 1'b0, 32'd0);
        start_seq(16'h8001, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        wait_done();

        // Empty list with writeback: one WB cycle, offset 0
        push(1'b0, 1'b1, 4'd0, 32'd0, 1'b0, 32'd0);
        start_seq(16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        wait_done();

        // Empty list without writeback: no activity at all
        start_seq(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        wait_done();

        // Reset in the middle of a full-list LDMIA
        for (int k = 0; k < 16; k++) begin
            push(1'b1, 1'b0, 4'(k), 32'(4 * k), (k != 15), 32'd0);
        end
        start_seq(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;

        // LDMDA {r0}: single transfer at offset 0
        push(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        start_seq(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        wait_done();

        // STMIA {r1,r2}! with a start pulse while busy
        push(1'b1, 1'b0, 4'd1, 32'd0, 1'b1, 32'h1000_0001);
        push(1'b1, 1'b0, 4'd2, 32'd4, 1'b1, 32'h1000_0002);
        push(1'b0, 1'b1, 4'd0, 32'd8, 1'b0, 32'd0);
        start_seq(16'h0006, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ldm_ctrl.md
Name: ldm_ctrl

Overview:
Sequencer for ARMv4 block transfers (LDM/STM). On a decoded block-transfer instruction it walks the 16-bit register list lowest-first. For each listed register it drives the EX-stage ldm override signals: a byte offset for the shift/ALU address path, a register code, store data and a memory-valid strobe. It then issues an optional base-writeback cycle and holds the upstream pipeline until done.

Parameters:
DATA_W, 32, width of offset and register data paths
WORD_BYTES, 4, address stride per transferred register

Ports:
i_clk  in  1  core clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  block-transfer instruction present in EX this cycle; sampled only in IDLE
i_reg_list  in  16  register list, bit k = Rk
i_load  in  1  1=LDM, 0=STM
i_up  in  1  U bit: 1=increment, 0=decrement
i_pre  in  1  P bit: 1=before, 0=after
i_wb  in  1  W bit: base writeback requested
i_stall  in  1  memory/pipeline stall; freezes sequencer state
o_ldm_vld  out  1  EX mux select (to ex_stage i_ldm_vld)
o_ldm_offset  out  DATA_W  offset magnitude; decoder fixes ALU ADD/SUB from U
o_ldm_mem_vld  out  1  memory access this cycle
o_ldm_reg_code  out  4  register being transferred
o_reg_rd_code  out  4  register-file read address (STM data)
i_reg_rd_data  in  DATA_W  register-file read data
o_ldm_reg  out  DATA_W  store data to EX (= i_reg_rd_data, combinational)
o_ldm_wb_base  out  1  base-writeback cycle; offset = WORD_BYTES*n
o_hold  out  1  stall fetch/decode; keep instruction in EX
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, remaining list=0, index i=0, count n=0. All outputs 0.
- States: IDLE, XFER, WB.
- IDLE & i_start & !i_stall:
  - latch list, L, U, P, W; n = popcount(list); i=0.
  - Go to XFER if n!=0.
  - Else go to WB if i_wb, else stay IDLE.
  - o_hold=1 in this cycle only if the next state != IDLE.
- XFER, one register per non-stalled cycle:
  - o_ldm_vld=1, o_ldm_mem_vld=1, o_ldm_reg_code = o_reg_rd_code = lowest set bit of remaining list.
  - Offset: IA 4*i; IB 4*(i+1); DA 4*(n-1-i); DB 4*(n-i) (stride = WORD_BYTES).
  - On advance: clear that bit, i++.
  - Last register (i==n-1): next state WB if W, else IDLE.
- WB, 1 cycle: o_ldm_vld=1, o_ldm_mem_vld=0, o_ldm_wb_base=1, o_ldm_offset=WORD_BYTES*n, o_ldm_reg_code=0. Then IDLE.
- o_hold=1 in every non-IDLE cycle except the final cycle of the sequence (last XFER with W=0, or WB). The decoder then advances in the following cycle.
- i_stall=1: state, list, i and all outputs frozen. o_hold stays asserted. Memory strobe is held, not repeated.
- i_start while busy: ignored.
- LDM with r15 in list: transferred last, since order is lowest-first. Pipeline flush is the WB-stage's job.
- Empty list: no memory cycles. W=1 gives a WB cycle with offset 0.
- Base in list with W: transfer uses the old base value, as read by the decoder at issue. Writeback happens after the transfers.
- Offsets are unsigned, max 64 bytes, zero-extended to DATA_W.

Decomposition:
- Shared def.v: LDM state encodings (IDLE/XFER/WB), WORD_BYTES, register-list width 16.
- One sub-module, prio_enc16: lowest-set-bit index plus valid flag. Reused for the popcount-free "last" detection (remaining list with lowest bit cleared == 0).

Test Plan:
- LDMIA list=0x000F, W=1: codes 0,1,2,3, offsets 0,4,8,12, mem_vld 4 cycles. Then WB offset 16; o_hold high 5 cycles, low on the WB cycle.
- STMDB list=0x4010 (r4, r14), W=0: codes 4,14, offsets 8,4; o_ldm_reg tracks i_reg_rd_data; o_ldm_wb_base never asserts; back to IDLE after 2 cycles.
- LDMIB list=0x8001, i_stall=1 for 3 cycles during r0: outputs frozen (code 0, offset 4). Then r15 with offset 8; no duplicate advance.
- Empty list, W=1 then W=0: single WB cycle offset 0, then no activity at all; mem_vld never 1.
- Assert i_rst mid-XFER of list 0xFFFF: all outputs 0 immediately. New i_start with list=0x0001 DA runs cleanly, offset 0.
- i_start pulsed while busy: ignored; sequence count and offsets unchanged.
